mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Multi-cycle CPU memory-access stage, directly upstream of the load-extension unit.
- Takes a load/store request from the main controller and computes the 4-bit byte-enable mask from the opcode and address.
- Aligns store data into byte lanes, runs a req/ack handshake with data memory with timeout supervision, and latches read data into the data register (dr_out).
- dr_out and be feed the load-extension unit.

Parameters:
- TIMEOUT, 16, maximum cycles mem_req is held without mem_ack before bus_err; legal range 2..255.
- AW, 32, address width.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  one-cycle request pulse from controller; sampled only in IDLE
- op  input  6  MIPS opcode (LW, LH, LHU, LB, LBU, SW, SH, SB from shared define file)
- addr  input  AW  byte address
- wdata  input  32  store source register value
- mem_req  output  1  bus request
- mem_we  output  1  1 = write
- mem_addr  output  AW  word address to memory ({addr[AW-1:2],2'b00})
- mem_wdata  output  32  lane-aligned store data
- mem_be  output  4  byte enables to memory
- mem_rdata  input  32  read data, valid in the cycle mem_ack is high
- mem_ack  input  1  one-cycle acknowledge
- be  output  4  registered byte-enable mask for load-extension unit
- dr_out  output  32  data register, raw memory word
- done  output  1  one-cycle completion pulse
- busy  output  1  high in any state except IDLE
- addr_err  output  1  one-cycle pulse: misaligned access, no bus cycle issued
- bus_err  output  1  one-cycle pulse: handshake timeout

Behaviour:
- Reset (asynchronous, rst=1): state=IDLE; mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_be=0, be=0, dr_out=0, done=0, busy=0, addr_err=0, bus_err=0; timeout counter=0.
- Byte enables, little-endian:
  - word: 4'b1111
  - half: addr[1]=0 -> 4'b0011, addr[1]=1 -> 4'b1100
  - byte: addr[1:0]=00/01/10/11 -> 0001/0010/0100/1000
- Alignment:
  - word requires addr[1:0]=00; half requires addr[0]=0; byte is always aligned.
- Store data lane placement:
  - SW: wdata as-is.
  - SH: {wdata[15:0],wdata[15:0]}.
  - SB: {4{wdata[7:0]}}.
  - Memory writes only the enabled lanes.
- Unknown opcode with start: treated as misaligned (addr_err pulse, no bus cycle).
- States:
  - IDLE:
    - start=0 -> stay.
    - start=1 and misaligned or illegal op -> ERR.
    - start=1 and aligned -> REQ. On this edge latch mem_addr, mem_we (1 for stores), mem_wdata, mem_be, be; set mem_req=1; clear counter.
  - REQ:
    - mem_req held with addr, data and enables stable; counter increments each cycle.
    - mem_ack=1 -> DONE. On a load, dr_out<=mem_rdata on that edge; on a store, dr_out is unchanged. mem_req drops on the same edge.
    - counter reaches TIMEOUT-1 without ack -> TOUT; mem_req drops.
    - mem_ack and timeout in the same cycle: ack wins.
  - DONE: done=1 for one cycle -> IDLE.
  - ERR: addr_err=1 for one cycle -> IDLE. be and dr_out unchanged.
  - TOUT: bus_err=1 for one cycle -> IDLE. dr_out unchanged.
- Latency: zero-wait memory (ack in first REQ cycle) gives start -> done = 2 edges later (start edge, ack edge, done visible in the following cycle).
- start while busy: ignored, no queuing.
- mem_ack outside REQ: ignored.
- be and dr_out hold their values until the next successful access, so the load-extension unit may sample them at any time after done.
- Reset mid-transaction: immediate return to IDLE and all outputs to reset values, including mem_req dropping asynchronously.

Test Plan:
- LW addr=0x100, ack after 3 wait cycles, mem_rdata=0xDEADBEEF -> mem_req high 4 cycles, mem_be=1111, mem_we=0, dr_out=0xDEADBEEF, be=1111, single done pulse.
- LB addr=0x103, zero-wait ack, mem_rdata=0x80112233 -> mem_addr=0x100, be=1000, dr_out=0x80112233, done 2 cycles after start.
- SH addr=0x202 wdata=0x0000ABCD -> mem_we=1, mem_be=1100, mem_wdata=0xABCDABCD, mem_addr=0x200; dr_out unchanged.
- LW addr=0x101 and SH addr=0x203 -> addr_err pulse each, mem_req never asserted, be/dr_out unchanged.
- TIMEOUT=16, LHU addr=0x10, no ack -> mem_req high exactly 16 cycles, then bus_err pulse, busy low next cycle. Repeat with ack on cycle 16 -> done, no bus_err.
- Assert rst in REQ after 2 wait cycles -> mem_req and busy low immediately (asynchronous); a late mem_ack is ignored; next start proceeds normally.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-access stage (master) and data memory (slave).
// Request fields are held stable for the whole req/ack handshake.
interface mem_access_unit_if #(
    parameter int AW = 32
);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic [31:0]   mem_rdata;
    logic          mem_ack;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Multi-cycle memory-access stage: decodes load/store size, aligns store lanes,
// runs a supervised req/ack handshake and holds be/dr_out for the load-extension unit.
module mem_access_unit #(
    parameter int TIMEOUT = 16,
    parameter int AW      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [5:0]          op,
    input  logic [AW-1:0]       addr,
    input  logic [31:0]         wdata,
    mem_access_unit_if.master   mem_bus,
    output logic [3:0]          be,
    output logic [31:0]         dr_out,
    output logic                done,
    output logic                busy,
    output logic                addr_err,
    output logic                bus_err
);
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_DONE = 3'd2,
        ST_ERR  = 3'd3,
        ST_TOUT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    state_t        state_r, state_nx;
    size_t         size_s;
    logic          is_load_s, is_store_s, aligned_s, accept_s;
    logic [3:0]    be_s;
    logic [31:0]   lane_wdata_s;

    logic          mem_req_r, mem_we_r;
    logic [AW-1:0] mem_addr_r;
    logic [31:0]   mem_wdata_r;
    logic [3:0]    mem_be_r, be_r;
    logic [31:0]   dr_out_r;
    logic          done_r, busy_r, addr_err_r, bus_err_r;
    logic [7:0]    cnt_r;

    // Opcode decode into access direction and size; unknown opcodes are neither.
    always_comb begin
        is_load_s  = 1'b0;
        is_store_s = 1'b0;
        size_s     = SZ_WORD;
        case (op)
            OP_LW:         begin is_load_s  = 1'b1; size_s = SZ_WORD; end
            OP_LH, OP_LHU: begin is_load_s  = 1'b1; size_s = SZ_HALF; end
            OP_LB, OP_LBU: begin is_load_s  = 1'b1; size_s = SZ_BYTE; end
            OP_SW:         begin is_store_s = 1'b1; size_s = SZ_WORD; end
            OP_SH:         begin is_store_s = 1'b1; size_s = SZ_HALF; end
            OP_SB:         begin is_store_s = 1'b1; size_s = SZ_BYTE; end
            default:       begin is_load_s  = 1'b0; is_store_s = 1'b0; size_s = SZ_WORD; end
        endcase
    end

    // Little-endian byte enables, alignment check and store lane replication.
    always_comb begin
        be_s         = 4'b0000;
        aligned_s    = 1'b0;
        lane_wdata_s = wdata;
        case (size_s)
            SZ_WORD: begin
                be_s         = 4'b1111;
                aligned_s    = (addr[1:0] == 2'b00);
                lane_wdata_s = wdata;
            end
            SZ_HALF: begin
                be_s         = addr[1] ? 4'b1100 : 4'b0011;
                aligned_s    = ~addr[0];
                lane_wdata_s = {2{wdata[15:0]}};
            end
            SZ_BYTE: begin
                be_s         = 4'b0001 << addr[1:0];
                aligned_s    = 1'b1;
                lane_wdata_s = {4{wdata[7:0]}};
            end
            default: begin
                be_s         = 4'b0000;
                aligned_s    = 1'b0;
                lane_wdata_s = wdata;
            end
        endcase
        accept_s = (is_load_s | is_store_s) & aligned_s;
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx;
        end
    end

    // Next-state logic; an ack in the last allowed cycle still wins over timeout.
    always_comb begin
        state_nx = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx = accept_s ? ST_REQ : ST_ERR;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (mem_bus.mem_ack) begin
                    state_nx = ST_DONE;
                end else if (cnt_r == TO_LAST) begin
                    state_nx = ST_TOUT;
                end else begin
                    state_nx = ST_REQ;
                end
            end
            ST_DONE: state_nx = ST_IDLE;
            ST_ERR:  state_nx = ST_IDLE;
            ST_TOUT: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    // Registered bus, status and data-register outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req_r   <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= 32'h0000_0000;
            mem_be_r    <= 4'b0000;
            be_r        <= 4'b0000;
            dr_out_r    <= 32'h0000_0000;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            addr_err_r  <= 1'b0;
            bus_err_r   <= 1'b0;
            cnt_r       <= 8'd0;
        end else begin
            done_r     <= (state_nx == ST_DONE);
            addr_err_r <= (state_nx == ST_ERR);
            bus_err_r  <= (state_nx == ST_TOUT);
            busy_r     <= (state_nx != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (start && accept_s) begin
                        mem_req_r   <= 1'b1;
                        mem_we_r    <= is_store_s;
                        mem_addr_r  <= {addr[AW-1:2], 2'b00};
                        mem_wdata_r <= lane_wdata_s;
                        mem_be_r    <= be_s;
                        be_r        <= be_s;
                        cnt_r       <= 8'd0;
                    end
                end
                ST_REQ: begin
                    if (mem_bus.mem_ack) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        mem_be_r  <= 4'b0000;
                        if (!mem_we_r) begin
                            dr_out_r <= mem_bus.mem_rdata;
                        end
                    end else if (cnt_r == TO_LAST) begin
                        mem_req_r <= 1'b0;
                        mem_we_r  <= 1'b0;
                        mem_be_r  <= 4'b0000;
                    end else begin
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign mem_bus.mem_req   = mem_req_r;
    assign mem_bus.mem_we    = mem_we_r;
    assign mem_bus.mem_addr  = mem_addr_r;
    assign mem_bus.mem_wdata = mem_wdata_r;
    assign mem_bus.mem_be    = mem_be_r;
    assign be                = be_r;
    assign dr_out            = dr_out_r;
    assign done              = done_r;
    assign busy              = busy_r;
    assign addr_err          = addr_err_r;
    assign bus_err           = bus_err_r;
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: hand-computed vectors checked by immediate assertions.
module tb_mem_access_unit;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SH  = 6'h29;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  op = 6'h00;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  be;
    logic [31:0] dr_out;
    logic        done, busy, addr_err, bus_err;

    int vectors = 0;
    int miscompares = 0;
    int reqs, dones, berrs, done_at, busy_after_err;

    mem_access_unit_if #(.AW(32)) bus ();

    mem_access_unit #(.TIMEOUT(16), .AW(32)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .addr     (addr),
        .wdata    (wdata),
        .mem_bus  (bus),
        .be       (be),
        .dr_out   (dr_out),
        .done     (done),
        .busy     (busy),
        .addr_err (addr_err),
        .bus_err  (bus_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a one-cycle start pulse; sampling point is just after the start edge.
    task automatic issue(input logic [5:0] o, input logic [31:0] a, input logic [31:0] wd);
        op = o; addr = a; wdata = wd; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Fixed 40-cycle window acting as memory: ack on REQ cycle ack_after+1.
    task automatic serve(input int ack_after, input logic [31:0] rd);
        int err_prev;
        reqs = 0; dones = 0; berrs = 0; done_at = -1; busy_after_err = -1; err_prev = 0;
        for (int i = 0; i < 40; i++) begin
            if (err_prev != 0) begin
                busy_after_err = int'(busy);
                err_prev = 0;
            end
            if (bus.mem_req) reqs++;
            if (done) begin
                dones++;
                if (done_at < 0) done_at = i;
            end
            if (bus_err) begin
                berrs++;
                err_prev = 1;
            end
            bus.mem_ack   = bus.mem_req && (reqs == ack_after + 1);
            bus.mem_rdata = bus.mem_ack ? rd : 32'h0;
            tick();
        end
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
    endtask

    initial begin
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        tick();
        tick();
        check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_be", {28'd0, be}, 32'd0);
        check("rst_dr_out", dr_out, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        tick();

        // LW 0x100, three wait cycles
        issue(OP_LW, 32'h0000_0100, 32'h0);
        check("lw_mem_req", {31'd0, bus.mem_req}, 32'd1);
        check("lw_mem_be", {28'd0, bus.mem_be}, 32'h0000_000F);
        check("lw_mem_we", {31'd0, bus.mem_we}, 32'd0);
        check("lw_mem_addr", bus.mem_addr, 32'h0000_0100);
        check("lw_busy", {31'd0, busy}, 32'd1);
        serve(3, 32'hDEAD_BEEF);
        check("lw_req_cycles", reqs, 32'd4);
        check("lw_dones", dones, 32'd1);
        check("lw_done_at", done_at, 32'd4);
        check("lw_dr_out", dr_out, 32'hDEAD_BEEF);
        check("lw_be", {28'd0, be}, 32'h0000_000F);

        // LB 0x103, zero-wait
        issue(OP_LB, 32'h0000_0103, 32'h0);
        check("lb_mem_addr", bus.mem_addr, 32'h0000_0100);
        check("lb_mem_be", {28'd0, bus.mem_be}, 32'h0000_0008);
        serve(0, 32'h8011_2233);
        check("lb_done_at", done_at, 32'd1);
        check("lb_dr_out", dr_out, 32'h8011_2233);
        check("lb_be", {28'd0, be}, 32'h0000_0008);

        // SH 0x202
        issue(OP_SH, 32'h0000_0202, 32'h0000_ABCD);
        check("sh_mem_we", {31'd0, bus.mem_we}, 32'd1);
        check("sh_mem_be", {28'd0, bus.mem_be}, 32'h0000_000C);
        check("sh_mem_wdata", bus.mem_wdata, 32'hABCD_ABCD);
        check("sh_mem_addr", bus.mem_addr, 32'h0000_0200);
        serve(0, 32'h5555_5555);
        check("sh_dones", dones, 32'd1);
        check("sh_dr_out", dr_out, 32'h8011_2233);
        check("sh_be", {28'd0, be}, 32'h0000_000C);

        // Misaligned LW 0x101, misaligned SH 0x203, unknown opcode
        issue(OP_LW, 32'h0000_0101, 32'h0);
        check("mis_lw_addr_err", {31'd0, addr_err}, 32'd1);
        check("mis_lw_req", {31'd0, bus.mem_req}, 32'd0);
        tick();
        check("mis_lw_pulse_end", {31'd0, addr_err}, 32'd0);
        check("mis_lw_busy", {31'd0, busy}, 32'd0);
        issue(OP_SH, 32'h0000_0203, 32'h1234_5678);
        check("mis_sh_addr_err", {31'd0, addr_err}, 32'd1);
        check("mis_sh_req", {31'd0, bus.mem_req}, 32'd0);
        tick();
        issue(6'h3F, 32'h0000_0000, 32'h0);
        check("illegal_addr_err", {31'd0, addr_err}, 32'd1);
        check("illegal_req", {31'd0, bus.mem_req}, 32'd0);
        tick();
        check("mis_be_hold", {28'd0, be}, 32'h0000_000C);
        check("mis_dr_hold", dr_out, 32'h8011_2233);

        // LHU 0x10 with no ack: timeout
        issue(OP_LHU, 32'h0000_0010, 32'h0);
        serve(99, 32'hFFFF_FFFF);
        check("tout_req_cycles", reqs, 32'd16);
        check("tout_bus_err", berrs, 32'd1);
        check("tout_dones", dones, 32'd0);
        check("tout_busy_after", busy_after_err, 32'd0);
        check("tout_dr_hold", dr_out, 32'h8011_2233);
        check("tout_be", {28'd0, be}, 32'h0000_0003);

        // LHU 0x10, ack on the 16th REQ cycle
        issue(OP_LHU, 32'h0000_0010, 32'h0);
        serve(15, 32'h1234_5678);
        check("late_ack_req_cycles", reqs, 32'd16);
        check("late_ack_dones", dones, 32'd1);
        check("late_ack_bus_err", berrs, 32'd0);
        check("late_ack_dr_out", dr_out, 32'h1234_5678);

        // Reset in REQ after two wait cycles
        issue(OP_LW, 32'h0000_0300, 32'h0);
        tick();
        tick();
        check("pre_rst_req", {31'd0, bus.mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_req", {31'd0, bus.mem_req}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;
        tick();
        check("stray_ack_done", {31'd0, done}, 32'd0);
        check("stray_ack_dr_out", dr_out, 32'd0);
        issue(OP_LB, 32'h0000_0001, 32'h0);
        serve(0, 32'h0000_AA00);
        check("post_rst_done_at", done_at, 32'd1);
        check("post_rst_dr_out", dr_out, 32'h0000_AA00);
        check("post_rst_be", {28'd0, be}, 32'h0000_0002);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
